rob_multiport: RTL and testbench

- Parametrised reorder buffer for the out-of-order RV32I core, successor to the single-writeback ROB.
- Sits between decoder/dispatch and regfile, reservation stations, LSB, predictor and ifetch.
- Generalised in depth and writeback-channel count; adds explicit valid/ready issue, an occupancy counter, same-cycle operand bypass, a store-commit handshake and mispredict flush with redirect PC.
- Allocates entries in program order, collects results from NUM_WB channels, retires at most one entry per cycle.

---
 rtl/rob_multiport_if.sv | 63 ++++++
 rtl/rob_multiport.sv | 194 +++++++++++++++++++
 tb/tb_rob_multiport.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_multiport_if.sv
// Dispatch, writeback, operand-query and retire bus of the multi-port reorder buffer.
interface rob_multiport_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TAG_W  = $clog2(DEPTH),
  parameter int unsigned NUM_WB = 2
);
  logic                     issue_valid;
  logic                     issue_ready;
  logic [1:0]               issue_type;
  logic [4:0]               issue_rd;
  logic [31:0]              issue_pc;
  logic                     issue_pred_taken;
  logic [TAG_W-1:0]         issue_tag;

  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*TAG_W-1:0]  wb_tag;
  logic [NUM_WB*32-1:0]     wb_val;
  logic [NUM_WB-1:0]        wb_taken;

  logic [TAG_W-1:0]         q1_tag;
  logic [TAG_W-1:0]         q2_tag;
  logic                     q1_ready;
  logic                     q2_ready;
  logic [31:0]              q1_val;
  logic [31:0]              q2_val;

  logic                     commit_valid;
  logic [4:0]               commit_rd;
  logic [31:0]              commit_val;
  logic [TAG_W-1:0]         commit_tag;
  logic                     store_commit_valid;
  logic [TAG_W-1:0]         store_commit_tag;
  logic                     lsb_store_ready;
  logic                     bp_update_valid;
  logic [31:0]              bp_update_pc;
  logic                     bp_update_taken;
  logic                     flush_out;
  logic [31:0]              flush_pc;
  logic [TAG_W:0]           count;
  logic                     empty;

  modport master (
    output issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
    output wb_valid, wb_tag, wb_val, wb_taken,
    output q1_tag, q2_tag, lsb_store_ready,
    input  issue_ready, issue_tag, q1_ready, q2_ready, q1_val, q2_val,
    input  commit_valid, commit_rd, commit_val, commit_tag,
    input  store_commit_valid, store_commit_tag,
    input  bp_update_valid, bp_update_pc, bp_update_taken,
    input  flush_out, flush_pc, count, empty
  );

  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
    input  wb_valid, wb_tag, wb_val, wb_taken,
    input  q1_tag, q2_tag, lsb_store_ready,
    output issue_ready, issue_tag, q1_ready, q2_ready, q1_val, q2_val,
    output commit_valid, commit_rd, commit_val, commit_tag,
    output store_commit_valid, store_commit_tag,
    output bp_update_valid, bp_update_pc, bp_update_taken,
    output flush_out, flush_pc, count, empty
  );
endinterface

// File: rtl/rob_multiport.sv
// Reorder buffer: in-order allocate, NUM_WB-channel out-of-order writeback,
// single in-order retire with store handshake and mispredict flush.
module rob_multiport #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TAG_W  = $clog2(DEPTH),
  parameter int unsigned NUM_WB = 2
) (
  input  logic            clk,
  input  logic            rst_in,
  input  logic            rdy_in,
  rob_multiport_if.slave  bus
);
  localparam int unsigned CNT_W = TAG_W + 1;

  typedef enum logic [1:0] {
    T_REG    = 2'd0,
    T_STORE  = 2'd1,
    T_BRANCH = 2'd2,
    T_NOP    = 2'd3
  } itype_e;

  typedef struct packed {
    logic        valid;
    logic        ready;
    itype_e      itype;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred_taken;
    logic        taken;
    logic [31:0] val;
  } entry_t;

  entry_t           ent [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [CNT_W-1:0] cnt;

  entry_t           head_e;
  logic             retire;
  logic             mispredict;
  logic             do_issue;
  logic             issue_ready_c;

  logic [TAG_W-1:0] wt     [NUM_WB];
  logic [31:0]      wv     [NUM_WB];
  logic [NUM_WB-1:0] wb_win;

  assign head_e        = ent[head];
  assign issue_ready_c = (cnt < CNT_W'(DEPTH)) && !bus.flush_out;
  assign bus.issue_ready = issue_ready_c;
  assign bus.issue_tag   = tail;
  assign bus.count       = cnt;
  assign bus.empty       = (cnt == '0);

  // Unpack channels; a channel loses to any lower channel carrying the same tag
  always_comb begin
    for (int unsigned c = 0; c < NUM_WB; c++) begin
      wt[c]     = bus.wb_tag[c*TAG_W +: TAG_W];
      wv[c]     = bus.wb_val[c*32 +: 32];
      wb_win[c] = bus.wb_valid[c];
      for (int unsigned l = 0; l < c; l++) begin
        if (bus.wb_valid[l] && (bus.wb_tag[l*TAG_W +: TAG_W] == bus.wb_tag[c*TAG_W +: TAG_W])) begin
          wb_win[c] = 1'b0;
        end
      end
    end
  end

  // Operand lookup with same-cycle writeback bypass
  always_comb begin
    bus.q1_ready = 1'b0;
    bus.q1_val   = '0;
    bus.q2_ready = 1'b0;
    bus.q2_val   = '0;
    if (ent[bus.q1_tag].valid) begin
      bus.q1_ready = ent[bus.q1_tag].ready;
      bus.q1_val   = ent[bus.q1_tag].val;
    end
    if (ent[bus.q2_tag].valid) begin
      bus.q2_ready = ent[bus.q2_tag].ready;
      bus.q2_val   = ent[bus.q2_tag].val;
    end
    for (int unsigned c = 0; c < NUM_WB; c++) begin
      if (wb_win[c] && (wt[c] == bus.q1_tag)) begin
        bus.q1_ready = 1'b1;
        bus.q1_val   = wv[c];
      end
      if (wb_win[c] && (wt[c] == bus.q2_tag)) begin
        bus.q2_ready = 1'b1;
        bus.q2_val   = wv[c];
      end
    end
  end

  // Head retire decision; stores wait for the LSB
  always_comb begin
    retire     = 1'b0;
    mispredict = 1'b0;
    if (head_e.valid && head_e.ready) begin
      retire = (head_e.itype != T_STORE) || bus.lsb_store_ready;
    end
    if (retire && (head_e.itype == T_BRANCH) && (head_e.taken != head_e.pred_taken)) begin
      mispredict = 1'b1;
    end
    do_issue = bus.issue_valid && issue_ready_c && !mispredict;
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
      bus.commit_valid       <= 1'b0;
      bus.commit_rd          <= '0;
      bus.commit_val         <= '0;
      bus.commit_tag         <= '0;
      bus.store_commit_valid <= 1'b0;
      bus.store_commit_tag   <= '0;
      bus.bp_update_valid    <= 1'b0;
      bus.bp_update_pc       <= '0;
      bus.bp_update_taken    <= 1'b0;
      bus.flush_out          <= 1'b0;
      bus.flush_pc           <= '0;
    end else if (rdy_in) begin
      bus.commit_valid       <= 1'b0;
      bus.store_commit_valid <= 1'b0;
      bus.bp_update_valid    <= 1'b0;
      bus.flush_out          <= mispredict;

      if (retire) begin
        case (head_e.itype)
          T_REG: begin
            if (head_e.rd != 5'd0) begin
              bus.commit_valid <= 1'b1;
              bus.commit_rd    <= head_e.rd;
              bus.commit_val   <= head_e.val;
              bus.commit_tag   <= head;
            end
          end
          T_STORE: begin
            bus.store_commit_valid <= 1'b1;
            bus.store_commit_tag   <= head;
          end
          T_BRANCH: begin
            bus.bp_update_valid <= 1'b1;
            bus.bp_update_pc    <= head_e.pc;
            bus.bp_update_taken <= head_e.taken;
          end
          default: ;
        endcase
      end

      if (mispredict) begin
        // Wrong-path entries and this cycle's issue/writeback are discarded
        bus.flush_pc <= head_e.val;
        head <= '0;
        tail <= '0;
        cnt  <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          ent[i].valid <= 1'b0;
          ent[i].ready <= 1'b0;
        end
      end else begin
        for (int unsigned c = 0; c < NUM_WB; c++) begin
          if (wb_win[c] && ent[wt[c]].valid && !ent[wt[c]].ready) begin
            ent[wt[c]].ready <= 1'b1;
            ent[wt[c]].val   <= wv[c];
            ent[wt[c]].taken <= bus.wb_taken[c];
          end
        end
        if (retire) begin
          ent[head].valid <= 1'b0;
          ent[head].ready <= 1'b0;
          head <= head + TAG_W'(1);
        end
        if (do_issue) begin
          ent[tail].valid      <= 1'b1;
          ent[tail].ready      <= (bus.issue_type == 2'd3);
          ent[tail].itype      <= itype_e'(bus.issue_type);
          ent[tail].rd         <= bus.issue_rd;
          ent[tail].pc         <= bus.issue_pc;
          ent[tail].pred_taken <= bus.issue_pred_taken;
          ent[tail].taken      <= 1'b0;
          ent[tail].val        <= 32'd0;
          tail <= tail + TAG_W'(1);
        end
        cnt <= cnt + CNT_W'(do_issue) - CNT_W'(retire);
      end
    end
  end
endmodule

// File: tb/tb_rob_multiport.sv
// Randomised scoreboard bench for rob_multiport against a queue-based program-order model.
module tb_rob_multiport;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned NUM_WB = 2;

  logic clk = 1'b0;
  logic rst_in;
  logic rdy_in;

  always #5 clk = ~clk;

  rob_multiport_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_WB(NUM_WB)) bus ();

  rob_multiport #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_WB(NUM_WB)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  typedef struct {
    int          tag;
    int          typ;
    int          rd;
    logic [31:0] pc;
    bit          pred;
    bit          ready;
    logic [31:0] val;
    bit          taken;
  } rec_t;

  // kind: 0 commit, 1 store commit, 2 predictor update, 3 flush
  typedef struct {
    int          cyc;
    int          kind;
    int          a;
    logic [31:0] b;
    int          tag;
  } ev_t;

  rec_t mq[$];
  ev_t  evq[$];
  int   mtail;
  bit   mflush;
  int   cyc;
  int   n_chk;
  int   n_pass;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Expected operand lookup: same-cycle writeback first (lowest channel), then program-order window
  task automatic qexp(input int t, output bit r, output logic [31:0] v, output bit vchk);
    r = 1'b0; v = 32'd0; vchk = 1'b1;
    for (int c = 0; c < int'(NUM_WB); c++) begin
      if (bus.wb_valid[c] && int'(bus.wb_tag[c*TAG_W +: TAG_W]) == t) begin
        r = 1'b1; v = bus.wb_val[c*32 +: 32];
        return;
      end
    end
    foreach (mq[i]) begin
      if (mq[i].tag == t) begin
        r = mq[i].ready; v = mq[i].val; vchk = mq[i].ready;
        return;
      end
    end
  endtask

  // Checks current observable state, then advances the model across the coming edge
  task automatic model_eval();
    bit          exp_ir, qr, qvc, mis;
    logic [31:0] qv;
    rec_t        e, n;
    int          t;
    chk("count", 64'(bus.count), 64'(mq.size()));
    chk("empty", 64'(bus.empty), 64'(mq.size() == 0));
    exp_ir = (mq.size() < int'(DEPTH)) && !mflush;
    chk("issue_ready", 64'(bus.issue_ready), 64'(exp_ir));
    chk("issue_tag", 64'(bus.issue_tag), 64'(mtail));
    qexp(int'(bus.q1_tag), qr, qv, qvc);
    chk("q1_ready", 64'(bus.q1_ready), 64'(qr));
    if (qvc) chk("q1_val", 64'(bus.q1_val), 64'(qv));
    qexp(int'(bus.q2_tag), qr, qv, qvc);
    chk("q2_ready", 64'(bus.q2_ready), 64'(qr));
    if (qvc) chk("q2_val", 64'(bus.q2_val), 64'(qv));
    if (!rdy_in) return;

    mis = 1'b0;
    if (mq.size() > 0 && mq[0].ready && (mq[0].typ != 1 || bus.lsb_store_ready)) begin
      e = mq.pop_front();
      case (e.typ)
        0: if (e.rd != 0) evq.push_back('{cyc, 0, e.rd, e.val, e.tag});
        1: evq.push_back('{cyc, 1, 0, 32'd0, e.tag});
        2: begin
          evq.push_back('{cyc, 2, int'(e.taken), e.pc, e.tag});
          if (e.taken != e.pred) begin
            mis = 1'b1;
            evq.push_back('{cyc, 3, 0, e.val, e.tag});
          end
        end
        default: ;
      endcase
    end
    mflush = mis;
    if (mis) begin
      mq.delete();
      mtail = 0;
    end else begin
      for (int c = 0; c < int'(NUM_WB); c++) begin
        if (bus.wb_valid[c]) begin
          t = int'(bus.wb_tag[c*TAG_W +: TAG_W]);
          foreach (mq[i]) begin
            if (mq[i].tag == t && !mq[i].ready) begin
              mq[i].ready = 1'b1;
              mq[i].val   = bus.wb_val[c*32 +: 32];
              mq[i].taken = bus.wb_taken[c];
            end
          end
        end
      end
      if (bus.issue_valid && exp_ir) begin
        n.tag = mtail; n.typ = int'(bus.issue_type); n.rd = int'(bus.issue_rd);
        n.pc = bus.issue_pc; n.pred = bus.issue_pred_taken;
        n.ready = (bus.issue_type == 2'd3); n.val = 32'd0; n.taken = 1'b0;
        mq.push_back(n);
        mtail = (mtail + 1) % int'(DEPTH);
      end
    end
  endtask

  task automatic clear_inputs();
    rdy_in               = 1'b1;
    bus.issue_valid      = 1'b0;
    bus.issue_type       = 2'd0;
    bus.issue_rd         = 5'd0;
    bus.issue_pc         = 32'd0;
    bus.issue_pred_taken = 1'b0;
    bus.wb_valid         = '0;
    bus.wb_tag           = '0;
    bus.wb_val           = '0;
    bus.wb_taken         = '0;
    bus.q1_tag           = '0;
    bus.q2_tag           = '0;
    bus.lsb_store_ready  = 1'b1;
  endtask

  task automatic set_issue(input int typ, input int rd, input bit pred);
    bus.issue_valid      = 1'b1;
    bus.issue_type       = 2'(typ);
    bus.issue_rd         = 5'(rd);
    bus.issue_pc         = $urandom;
    bus.issue_pred_taken = pred;
  endtask

  task automatic set_wb(input int ch, input int tag, input logic [31:0] val, input bit taken);
    bus.wb_valid[ch]              = 1'b1;
    bus.wb_tag[ch*TAG_W +: TAG_W] = TAG_W'(tag);
    bus.wb_val[ch*32 +: 32]       = val;
    bus.wb_taken[ch]              = taken;
  endtask

  task automatic step();
    cyc++;
    #1;
    model_eval();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_in = 1'b1;
    rdy_in = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_in = 1'b0;
    rdy_in = 1'b1;
    mq.delete();
    mtail  = 0;
    mflush = 1'b0;
    #1;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
    chk("rst_commit_val", 64'(bus.commit_val), 64'd0);
    chk("rst_store_valid", 64'(bus.store_commit_valid), 64'd0);
    chk("rst_flush_out", 64'(bus.flush_out), 64'd0);
    chk("rst_flush_pc", 64'(bus.flush_pc), 64'd0);
    chk("rst_issue_tag", 64'(bus.issue_tag), 64'd0);
    @(negedge clk);
  endtask

  // Monitor: pulses seen after each enabled edge must match the events the model scheduled for it
  always @(posedge clk) begin : monitor
    bit          live, held, x_cv, x_sv, x_bv, x_fv, x_bt;
    int          cy, x_rd, x_ctag, x_stag;
    logic [31:0] x_val, x_pc, x_fpc;
    logic [3:0]  now_p, prev_p;
    ev_t         e;
    live = rdy_in && !rst_in;
    held = !rdy_in && !rst_in;
    cy   = cyc;
    #2;
    now_p = {bus.commit_valid, bus.store_commit_valid, bus.bp_update_valid, bus.flush_out};
    if (live) begin
      x_cv = 0; x_sv = 0; x_bv = 0; x_fv = 0; x_bt = 0;
      x_rd = 0; x_ctag = 0; x_stag = 0; x_val = 0; x_pc = 0; x_fpc = 0;
      while (evq.size() > 0 && evq[0].cyc == cy) begin
        e = evq.pop_front();
        case (e.kind)
          0: begin x_cv = 1; x_rd = e.a; x_val = e.b; x_ctag = e.tag; end
          1: begin x_sv = 1; x_stag = e.tag; end
          2: begin x_bv = 1; x_pc = e.b; x_bt = (e.a != 0); end
          default: begin x_fv = 1; x_fpc = e.b; end
        endcase
      end
      chk("commit_valid", 64'(bus.commit_valid), 64'(x_cv));
      if (x_cv && bus.commit_valid) begin
        chk("commit_rd", 64'(bus.commit_rd), 64'(x_rd));
        chk("commit_val", 64'(bus.commit_val), 64'(x_val));
        chk("commit_tag", 64'(bus.commit_tag), 64'(x_ctag));
      end
      chk("store_commit_valid", 64'(bus.store_commit_valid), 64'(x_sv));
      if (x_sv && bus.store_commit_valid) chk("store_commit_tag", 64'(bus.store_commit_tag), 64'(x_stag));
      chk("bp_update_valid", 64'(bus.bp_update_valid), 64'(x_bv));
      if (x_bv && bus.bp_update_valid) begin
        chk("bp_update_pc", 64'(bus.bp_update_pc), 64'(x_pc));
        chk("bp_update_taken", 64'(bus.bp_update_taken), 64'(x_bt));
      end
      chk("flush_out", 64'(bus.flush_out), 64'(x_fv));
      if (x_fv && bus.flush_out) chk("flush_pc", 64'(bus.flush_pc), 64'(x_fpc));
    end else if (held) begin
      chk("hold_pulses", 64'(now_p), 64'(prev_p));
    end
    prev_p = now_p;
  end

  initial begin
    int r, typ, idx;
    n_chk = 0; n_pass = 0; cyc = 0;
    clear_inputs();
    rst_in = 1'b1;
    do_reset();

    // Fill all 16 entries, attempt one more, then retire tag 0 via channel 1
    for (int i = 0; i < int'(DEPTH); i++) begin
      clear_inputs(); set_issue(0, i + 1, 1'b0); step();
    end
    #1 chk("full_issue_ready", 64'(bus.issue_ready), 64'd0);
    clear_inputs(); set_issue(0, 20, 1'b0); step();
    clear_inputs(); set_wb(1, 0, 32'h5, 1'b0); step();
    for (int i = 0; i < 3; i++) begin clear_inputs(); step(); end

    // Out-of-order writeback, in-order retire
    do_reset();
    for (int i = 0; i < 3; i++) begin clear_inputs(); set_issue(0, i + 1, 1'b0); step(); end
    for (int t = 2; t >= 0; t--) begin clear_inputs(); set_wb(0, t, 32'h100 + 32'(t), 1'b0); step(); end
    for (int i = 0; i < 4; i++) begin clear_inputs(); step(); end

    // Store held at head until the LSB is ready
    do_reset();
    clear_inputs(); set_issue(1, 0, 1'b0); step();
    clear_inputs(); set_wb(0, 0, 32'h0, 1'b0); step();
    for (int i = 0; i < 3; i++) begin clear_inputs(); bus.lsb_store_ready = 1'b0; step(); end
    for (int i = 0; i < 3; i++) begin clear_inputs(); step(); end

    // Mispredicted branch with three younger entries; issue in the flush cycle is dropped
    do_reset();
    clear_inputs(); set_issue(2, 0, 1'b0); step();
    for (int i = 0; i < 3; i++) begin clear_inputs(); set_issue(0, i + 5, 1'b0); step(); end
    clear_inputs(); set_wb(0, 0, 32'h1000, 1'b1); step();
    clear_inputs(); set_issue(0, 9, 1'b0); step();
    #1 chk("flush_empty", 64'(bus.empty), 64'd1);
    for (int i = 0; i < 3; i++) begin clear_inputs(); step(); end

    // Duplicate-tag writeback on both channels: channel 0 wins
    do_reset();
    for (int i = 0; i < 4; i++) begin clear_inputs(); set_issue(0, i + 1, 1'b0); step(); end
    clear_inputs(); bus.q1_tag = 4'd3;
    set_wb(0, 3, 32'hA, 1'b0); set_wb(1, 3, 32'hB, 1'b0); step();
    clear_inputs(); bus.q1_tag = 4'd3;
    #1 chk("dual_stored_val", 64'(bus.q1_val), 64'hA);
    step();

    // Random traffic with rdy_in toggling; long enough to wrap tags many times
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      clear_inputs();
      rdy_in = ($urandom_range(0, 3) != 0);
      bus.lsb_store_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 6) begin
        r = $urandom_range(0, 19);
        typ = (r < 12) ? 0 : (r < 15) ? 1 : (r < 18) ? 2 : 3;
        set_issue(typ, $urandom_range(0, 31), 1'($urandom_range(0, 1)));
      end
      for (int c = 0; c < int'(NUM_WB); c++) begin
        if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
          idx = $urandom_range(0, mq.size() - 1);
          set_wb(c, mq[idx].tag, $urandom,
                 (mq[idx].typ == 2 && $urandom_range(0, 4) != 0) ? mq[idx].pred : 1'($urandom_range(0, 1)));
        end else if ($urandom_range(0, 7) == 0) begin
          set_wb(c, $urandom_range(0, DEPTH - 1), $urandom, 1'($urandom_range(0, 1)));
        end
      end
      bus.q1_tag = TAG_W'($urandom_range(0, DEPTH - 1));
      bus.q2_tag = TAG_W'($urandom_range(0, DEPTH - 1));
      step();
    end
    for (int i = 0; i < 3; i++) begin clear_inputs(); step(); end
    chk("events_drained", 64'(evq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
